// File: rtl/cache_l1_controller.sv
// Per-core L1 controller: two direct-mapped one-byte lines with MSI state, a
// single outstanding L2 request (optional dirty writeback first), and snoop service.
module cache_l1_controller (
  input  logic       clk,
  input  logic       resetN,
  input  logic       cpuValid,
  input  logic       cpuWrite,
  input  logic [7:0] cpuAddress,
  input  logic [7:0] cpuWriteData,
  output logic       cpuReady,
  output logic       cpuDone,
  output logic [7:0] cpuReadData,
  output logic       requestValid,
  output logic [7:0] addressBypass,
  output logic       operationBypass,
  output logic [7:0] dataBypass,
  output logic       dataWriteBack,
  input  logic [7:0] fetchData,
  input  logic       fetchPresent,
  input  logic [7:0] addressBypassL2,
  input  logic [2:0] interconnectionMessage,
  output logic       snoopAck,
  output logic       snoopHit,
  output logic [7:0] snoopData
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_REQUEST   = 2'd2;
  localparam logic [1:0] ST_COMPLETE  = 2'd3;

  localparam logic [1:0] LS_I = 2'd0;
  localparam logic [1:0] LS_S = 2'd1;
  localparam logic [1:0] LS_M = 2'd2;

  localparam logic [2:0] MSG_INV       = 3'd1;
  localparam logic [2:0] MSG_FETCH     = 3'd2;
  localparam logic [2:0] MSG_FETCH_INV = 3'd3;

  logic [1:0]      state_q, state_d;
  logic [1:0][1:0] line_state_q, line_state_d;
  logic [1:0][6:0] line_tag_q, line_tag_d;
  logic [1:0][7:0] line_data_q, line_data_d;
  logic [7:0]      req_addr_q, req_addr_d;
  logic            req_write_q, req_write_d;
  logic [7:0]      req_wdata_q, req_wdata_d;
  logic            request_valid_q, request_valid_d;
  logic [7:0]      addr_bypass_q, addr_bypass_d;
  logic            op_bypass_q, op_bypass_d;
  logic [7:0]      data_bypass_q, data_bypass_d;
  logic            data_wb_q, data_wb_d;
  logic            cpu_done_q, cpu_done_d;
  logic [7:0]      cpu_rdata_q, cpu_rdata_d;
  logic            snoop_ack_q, snoop_ack_d;
  logic            snoop_hit_q, snoop_hit_d;
  logic [7:0]      snoop_data_q, snoop_data_d;

  logic       snoop_idx, snoop_match;
  logic       cpu_idx, cpu_hit, req_idx;
  logic [7:0] fill_byte;

  assign snoop_idx   = addressBypassL2[0];
  assign snoop_match = (line_state_q[snoop_idx] != LS_I) &&
                       (line_tag_q[snoop_idx] == addressBypassL2[7:1]);
  assign cpu_idx     = cpuAddress[0];
  assign cpu_hit     = (line_state_q[cpu_idx] != LS_I) &&
                       (line_tag_q[cpu_idx] == cpuAddress[7:1]);
  assign req_idx     = req_addr_q[0];
  assign fill_byte   = req_write_q ? req_wdata_q : fetchData;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    state_d         = state_q;
    line_state_d    = line_state_q;
    line_tag_d      = line_tag_q;
    line_data_d     = line_data_q;
    req_addr_d      = req_addr_q;
    req_write_d     = req_write_q;
    req_wdata_d     = req_wdata_q;
    request_valid_d = request_valid_q;
    addr_bypass_d   = addr_bypass_q;
    op_bypass_d     = op_bypass_q;
    data_bypass_d   = data_bypass_q;
    data_wb_d       = data_wb_q;
    cpu_done_d      = 1'b0;
    cpu_rdata_d     = cpu_rdata_q;
    snoop_ack_d     = 1'b0;
    snoop_hit_d     = 1'b0;
    snoop_data_d    = 8'h00;

    // Snoop goes first so that a same-cycle fill or writeback retirement below wins.
    if (interconnectionMessage inside {MSG_INV, MSG_FETCH, MSG_FETCH_INV}) begin
      snoop_ack_d  = 1'b1;
      snoop_hit_d  = snoop_match && (line_state_q[snoop_idx] == LS_M);
      snoop_data_d = line_data_q[snoop_idx];
      if (snoop_match) begin
        if (interconnectionMessage == MSG_FETCH) begin
          if (line_state_q[snoop_idx] == LS_M) line_state_d[snoop_idx] = LS_S;
        end else begin
          line_state_d[snoop_idx] = LS_I;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cpuValid) begin
          req_addr_d  = cpuAddress;
          req_write_d = cpuWrite;
          req_wdata_d = cpuWriteData;
          if (cpu_hit && (!cpuWrite || line_state_q[cpu_idx] == LS_M)) begin
            if (cpuWrite) line_data_d[cpu_idx] = cpuWriteData;
            cpu_done_d  = 1'b1;
            cpu_rdata_d = cpuWrite ? cpuWriteData : line_data_q[cpu_idx];
            state_d     = ST_COMPLETE;
          end else if (!cpu_hit && line_state_q[cpu_idx] == LS_M) begin
            request_valid_d = 1'b1;
            data_wb_d       = 1'b1;
            op_bypass_d     = 1'b0;
            addr_bypass_d   = {line_tag_q[cpu_idx], cpu_idx};
            data_bypass_d   = line_data_q[cpu_idx];
            state_d         = ST_WRITEBACK;
          end else begin
            // Covers both a clean miss and an upgrade of a shared line on store.
            request_valid_d = 1'b1;
            data_wb_d       = 1'b0;
            op_bypass_d     = cpuWrite;
            addr_bypass_d   = cpuAddress;
            state_d         = ST_REQUEST;
          end
        end
      end
      ST_WRITEBACK: begin
        if (request_valid_q && fetchPresent) begin
          line_state_d[req_idx] = LS_I;
          data_wb_d             = 1'b0;
          op_bypass_d           = req_write_q;
          addr_bypass_d         = req_addr_q;
          state_d               = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (request_valid_q && fetchPresent) begin
          line_tag_d[req_idx]   = req_addr_q[7:1];
          line_data_d[req_idx]  = fill_byte;
          line_state_d[req_idx] = req_write_q ? LS_M : LS_S;
          request_valid_d       = 1'b0;
          cpu_done_d            = 1'b1;
          cpu_rdata_d           = fill_byte;
          state_d               = ST_COMPLETE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments only in clocked logic so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= ST_IDLE;
      // NOTE: the line array is tiny and must come up Invalid, so it is reset like any register.
      line_state_q    <= '0;
      line_tag_q      <= '0;
      line_data_q     <= '0;
      req_addr_q      <= '0;
      req_write_q     <= 1'b0;
      req_wdata_q     <= '0;
      request_valid_q <= 1'b0;
      addr_bypass_q   <= '0;
      op_bypass_q     <= 1'b0;
      data_bypass_q   <= '0;
      data_wb_q       <= 1'b0;
      cpu_done_q      <= 1'b0;
      cpu_rdata_q     <= '0;
      snoop_ack_q     <= 1'b0;
      snoop_hit_q     <= 1'b0;
      snoop_data_q    <= '0;
    end else begin
      state_q         <= state_d;
      line_state_q    <= line_state_d;
      line_tag_q      <= line_tag_d;
      line_data_q     <= line_data_d;
      req_addr_q      <= req_addr_d;
      req_write_q     <= req_write_d;
      req_wdata_q     <= req_wdata_d;
      request_valid_q <= request_valid_d;
      addr_bypass_q   <= addr_bypass_d;
      op_bypass_q     <= op_bypass_d;
      data_bypass_q   <= data_bypass_d;
      data_wb_q       <= data_wb_d;
      cpu_done_q      <= cpu_done_d;
      cpu_rdata_q     <= cpu_rdata_d;
      snoop_ack_q     <= snoop_ack_d;
      snoop_hit_q     <= snoop_hit_d;
      snoop_data_q    <= snoop_data_d;
    end
  end

  assign cpuReady        = (state_q == ST_IDLE);
  assign cpuDone         = cpu_done_q;
  assign cpuReadData     = cpu_rdata_q;
  assign requestValid    = request_valid_q;
  assign addressBypass   = addr_bypass_q;
  assign operationBypass = op_bypass_q;
  assign dataBypass      = data_bypass_q;
  assign dataWriteBack   = data_wb_q;
  assign snoopAck        = snoop_ack_q;
  assign snoopHit        = snoop_hit_q;
  assign snoopData       = snoop_data_q;

endmodule

// File: tb/tb_cache_l1_controller.sv
// Self-checking bench for cache_l1_controller: table-driven CPU transactions with
// an L2 responder and read-data scoreboard, plus hand-written snoop/reset sequences.
module tb_cache_l1_controller;

  logic       clk = 1'b0;
  logic       resetN;
  logic       cpuValid, cpuWrite;
  logic [7:0] cpuAddress, cpuWriteData;
  logic       cpuReady, cpuDone;
  logic [7:0] cpuReadData;
  logic       requestValid, operationBypass, dataWriteBack;
  logic [7:0] addressBypass, dataBypass;
  logic [7:0] fetchData;
  logic       fetchPresent;
  logic [7:0] addressBypassL2;
  logic [2:0] interconnectionMessage;
  logic       snoopAck, snoopHit;
  logic [7:0] snoopData;

  cache_l1_controller dut (
    .clk(clk), .resetN(resetN),
    .cpuValid(cpuValid), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress),
    .cpuWriteData(cpuWriteData), .cpuReady(cpuReady), .cpuDone(cpuDone),
    .cpuReadData(cpuReadData), .requestValid(requestValid),
    .addressBypass(addressBypass), .operationBypass(operationBypass),
    .dataBypass(dataBypass), .dataWriteBack(dataWriteBack),
    .fetchData(fetchData), .fetchPresent(fetchPresent),
    .addressBypassL2(addressBypassL2),
    .interconnectionMessage(interconnectionMessage),
    .snoopAck(snoopAck), .snoopHit(snoopHit), .snoopData(snoopData)
  );

  always #5 clk = ~clk;

  localparam int K_HIT = 0, K_MISS = 1, K_DIRTY = 2;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         kind;
    logic [7:0] wb_addr;
    logic [7:0] wb_data;
    logic       op;
    logic [7:0] fill;
    logic [7:0] rdata;
  } txn_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  string      ctx      = "init";
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", ctx, name, act, exp);
    end
  endtask

  task automatic run_txn(input txn_t t);
    int guard = 0;
    while (!cpuReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready", cpuReady, 1);
    cpuValid = 1'b1; cpuWrite = t.wr; cpuAddress = t.addr; cpuWriteData = t.wdata;
    sb.push_back(t.rdata);
    @(negedge clk);
    // Scramble the request fields: the controller must use the values latched at accept.
    cpuValid = 1'b0; cpuWrite = ~t.wr; cpuAddress = 8'hFF; cpuWriteData = ~t.wdata;
    if (t.kind == K_DIRTY) begin
      check("wb_valid", requestValid, 1);
      check("wb_flag", dataWriteBack, 1);
      check("wb_addr", addressBypass, t.wb_addr);
      check("wb_data", dataBypass, t.wb_data);
      fetchPresent = 1'b1; fetchData = 8'hEE;
      @(negedge clk);
      fetchPresent = 1'b0;
    end
    if (t.kind != K_HIT) begin
      check("req_valid", requestValid, 1);
      check("req_flag", dataWriteBack, 0);
      check("req_addr", addressBypass, t.addr);
      check("req_op", operationBypass, t.op);
      fetchPresent = 1'b1; fetchData = t.fill;
      @(negedge clk);
      fetchPresent = 1'b0; fetchData = 8'h00;
    end else begin
      check("hit_no_req", requestValid, 0);
    end
    check("done", cpuDone, 1);
    if (cpuDone && sb.size() > 0) check("rdata", cpuReadData, sb.pop_front());
    @(negedge clk);
    check("done_pulse", cpuDone, 0);
    check("ready_again", cpuReady, 1);
    check("idle_no_req", requestValid, 0);
  endtask

  task automatic snoop(input logic [2:0] msg, input logic [7:0] a, input logic exp_ack,
                       input logic exp_hit, input logic [7:0] exp_data);
    interconnectionMessage = msg; addressBypassL2 = a;
    @(negedge clk);
    interconnectionMessage = 3'd0;
    check("snoop_ack", snoopAck, exp_ack);
    check("snoop_hit", snoopHit, exp_hit);
    if (exp_hit) check("snoop_data", snoopData, exp_data);
    @(negedge clk);
    check("snoop_ack_pulse", snoopAck, 0);
  endtask

  txn_t vec[8];
  txn_t post[4];

  initial begin
    //          wr    addr   wdata  kind     wb_addr wb_data op    fill   rdata
    vec[0] = '{1'b0, 8'h10, 8'h00, K_MISS,  8'h00,  8'h00,  1'b0, 8'hAA, 8'hAA};
    vec[1] = '{1'b0, 8'h10, 8'h00, K_HIT,   8'h00,  8'h00,  1'b0, 8'h00, 8'hAA};
    vec[2] = '{1'b1, 8'h10, 8'h55, K_MISS,  8'h00,  8'h00,  1'b1, 8'hAA, 8'h55};
    vec[3] = '{1'b0, 8'h10, 8'h00, K_HIT,   8'h00,  8'h00,  1'b0, 8'h00, 8'h55};
    vec[4] = '{1'b1, 8'h20, 8'h77, K_DIRTY, 8'h10,  8'h55,  1'b1, 8'h12, 8'h77};
    vec[5] = '{1'b0, 8'h20, 8'h00, K_HIT,   8'h00,  8'h00,  1'b0, 8'h00, 8'h77};
    vec[6] = '{1'b0, 8'h23, 8'h00, K_MISS,  8'h00,  8'h00,  1'b0, 8'h3C, 8'h3C};
    vec[7] = '{1'b1, 8'h23, 8'h99, K_MISS,  8'h00,  8'h00,  1'b1, 8'h3C, 8'h99};
    // After the snoops: both lines invalid again, so these miss; then a hit on the refill.
    post[0] = '{1'b0, 8'h20, 8'h00, K_MISS, 8'h00, 8'h00, 1'b0, 8'h66, 8'h66};
    post[1] = '{1'b0, 8'h23, 8'h00, K_MISS, 8'h00, 8'h00, 1'b0, 8'h5A, 8'h5A};
    post[2] = '{1'b0, 8'h20, 8'h00, K_HIT,  8'h00, 8'h00, 1'b0, 8'h00, 8'h66};
    post[3] = '{1'b0, 8'h30, 8'h00, K_MISS, 8'h00, 8'h00, 1'b0, 8'h44, 8'h44};

    resetN = 1'b0; cpuValid = 1'b0; cpuWrite = 1'b0; cpuAddress = 8'h00; cpuWriteData = 8'h00;
    fetchData = 8'h00; fetchPresent = 1'b0; addressBypassL2 = 8'h00; interconnectionMessage = 3'd0;
    repeat (3) @(negedge clk);
    ctx = "reset";
    check("cpuReady", cpuReady, 1);
    check("cpuDone", cpuDone, 0);
    check("cpuReadData", cpuReadData, 0);
    check("requestValid", requestValid, 0);
    check("addressBypass", addressBypass, 0);
    check("operationBypass", operationBypass, 0);
    check("dataBypass", dataBypass, 0);
    check("dataWriteBack", dataWriteBack, 0);
    check("snoopAck", snoopAck, 0);
    check("snoopHit", snoopHit, 0);
    check("snoopData", snoopData, 0);
    resetN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      ctx = $sformatf("vec%0d", i);
      run_txn(vec[i]);
    end

    ctx = "snoop_fetch_m";
    snoop(3'd2, 8'h20, 1'b1, 1'b1, 8'h77);
    ctx = "snoop_inv_s";
    snoop(3'd1, 8'h20, 1'b1, 1'b0, 8'h00);
    ctx = "snoop_finv_m";
    snoop(3'd3, 8'h23, 1'b1, 1'b1, 8'h99);
    ctx = "snoop_ignored";
    snoop(3'd6, 8'h20, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 2; i++) begin
      ctx = $sformatf("post%0d", i);
      run_txn(post[i]);
    end

    ctx = "stray_fetch";
    fetchPresent = 1'b1; fetchData = 8'hDD;
    @(negedge clk);
    fetchPresent = 1'b0; fetchData = 8'h00;
    check("no_done", cpuDone, 0);
    check("still_ready", cpuReady, 1);
    ctx = "post2";
    run_txn(post[2]);

    ctx = "snoop_during_req";
    cpuValid = 1'b1; cpuWrite = 1'b0; cpuAddress = 8'h30;
    @(negedge clk);
    cpuValid = 1'b0;
    check("req_valid", requestValid, 1);
    check("req_addr", addressBypass, 8'h30);
    check("req_op", operationBypass, 0);
    interconnectionMessage = 3'd3; addressBypassL2 = 8'h21;
    @(negedge clk);
    interconnectionMessage = 3'd5;
    check("ack", snoopAck, 1);
    check("hit", snoopHit, 0);
    check("req_kept", requestValid, 1);
    check("req_addr_kept", addressBypass, 8'h30);
    @(negedge clk);
    interconnectionMessage = 3'd0;
    check("msg5_no_ack", snoopAck, 0);
    check("req_kept2", requestValid, 1);

    ctx = "reset_mid_req";
    #2 resetN = 1'b0;
    #1;
    check("requestValid", requestValid, 0);
    check("cpuReady", cpuReady, 1);
    check("addressBypass", addressBypass, 0);
    check("cpuDone", cpuDone, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    ctx = "post3";
    run_txn(post[3]);

    ctx = "end";
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
